// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and fetch constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/clear; head is visible combinationally for decode.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] we;
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = push && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Entries are reset so that instr/instr_pc read zero straight out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem[i] <= '0;
      end else if (we[i]) begin
        mem[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word reads, buffers returned words for decode.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect targets raise a sticky flag and halt fetch.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCsrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, rsp_pc_reg;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_use;
  logic [31:0]   target;
  logic          halt, req_fire, rsp_push, pop, fifo_empty;
  logic [63:0]   fifo_head;

`ifdef FETCH_MISALIGN_EN
  logic misaligned_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_reg <= 1'b0;
    end else if (PCsrc) begin
      misaligned_reg <= (PCTarget[1:0] != 2'b00);
    end
  end

  assign target     = PCTarget;
  assign halt       = misaligned_reg;
  assign misaligned = misaligned_reg;
`else
  assign target     = PCTarget & ~32'h3;
  assign halt       = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign in_use   = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_push = (state_reg == S_RUN) && imem_rsp_valid && !PCsrc;
  assign pop      = instr_valid && instr_ready;

  always_comb begin
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_BOOT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    imem_req_valid = 1'b0;
    discard_next   = discard_reg;
    case (state_reg)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   imem_req_valid = !halt && (in_use < DEPTH_W);
      S_FLUSH: begin
        if (imem_rsp_valid) discard_next = discard_reg - 1'b1;
        if (discard_next == '0) state_next = S_RUN;
      end
      default: state_next = S_BOOT;
    endcase
    // Everything still in flight after this edge is wrong-path, including a same-cycle accept.
    if (PCsrc) begin
      discard_next = outstanding_next;
      state_next   = (outstanding_next != '0) ? S_FLUSH : S_RUN;
    end
  end

  // rsp_pc_reg tracks the PC of the next response to be kept; responses return in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      if (PCsrc) begin
        fetch_pc_reg <= target;
        rsp_pc_reg   <= target;
      end else begin
        if (req_fire) fetch_pc_reg <= fetch_pc_reg + WORD_BYTES;
        if (rsp_push) rsp_pc_reg   <= rsp_pc_reg + WORD_BYTES;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data ({imem_rdata, rsp_pc_reg}),
    .pop       (pop),
    .clear     (PCsrc),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_addr   = fetch_pc_reg;
  assign instr       = fifo_head[63:32];
  assign instr_pc    = fifo_head[31:0];
  assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order, variable-latency instruction memory model.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrc;
  logic [31:0] PCTarget;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misaligned;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          due_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_pop_pc;
  int cyc = 0, lat = 0, n_req = 0, n_pops = 0;
  int n_cmp = 0, n_err = 0;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCsrc          (PCsrc),
    .PCTarget       (PCTarget),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] tgt_model(input logic [31:0] t);
`ifdef FETCH_MISALIGN_EN
    return t;
`else
    return t & ~32'h3;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive memory response, model this edge's events, advance to next negedge.
  task automatic step();
    logic acc, pp;
    exp_t e;
    if (mem_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = memfn(mem_q[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
    end
    #1;
    acc = imem_req_valid && imem_req_ready;
    pp  = instr_valid && instr_ready;
    if (pp) begin
      check_val("pop_has_exp", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("instr_pc", instr_pc, e.pc);
        check_val("instr", instr, e.w);
        $display("pop  pc=%h instr=%h cycle=%0d", instr_pc, instr, cyc);
      end
      last_pop_pc = instr_pc;
      n_pops++;
    end
    if (imem_rsp_valid) begin
      mem_q.delete(0);
      due_q.delete(0);
    end
    if (PCsrc) begin
      exp_q.delete();
      exp_pc = tgt_model(PCTarget);
    end
    if (acc) begin
      mem_q.push_back(imem_addr);
      due_q.push_back(cyc + 1 + lat);
      if (!PCsrc) begin
        check_val("req_addr", imem_addr, exp_pc);
        exp_q.push_back('{pc: exp_pc, w: memfn(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      n_req++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(input logic [31:0] t);
    PCsrc    = 1'b1;
    PCTarget = t;
    step();
    PCsrc    = 1'b0;
    PCTarget = '0;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] want_pc);
    int base;
    base = n_pops;
    for (int i = 0; i < 30 && n_pops == base; i++) step();
    check_val({tag, "_popped"}, {31'b0, n_pops != base}, 32'd1);
    if (n_pops != base) check_val({tag, "_pc"}, last_pop_pc, want_pc);
  endtask

  initial begin
    int base;
    rst = 1'b1; PCsrc = 1'b0; PCTarget = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0;
    exp_pc = RPC; last_pop_pc = '0;
    @(negedge clk);
    steps(3);

    check_val("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_val("rst_addr", imem_addr, RPC);
    check_val("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_instr_pc", instr_pc, 32'd0);
    check_val("rst_misaligned", {31'b0, misaligned}, 32'd0);

    // Release reset: BOOT cycle, then back-to-back fetch from RESET_PC.
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    check_val("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    check_val("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_val("c1_addr", imem_addr, RPC);
    step();
    check_val("c2_addr", imem_addr, RPC + 32'd4);
    check_val("c2_instr_valid", {31'b0, instr_valid}, 32'd0);
    step();
    check_val("c3_instr_valid", {31'b0, instr_valid}, 32'd1);
    check_val("c3_instr_pc", instr_pc, RPC);
    steps(10);

    // Backpressure from decode: exactly DEPTH requests, then none.
    imem_req_ready = 1'b0;
    steps(5);
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    base = n_req;
    steps(12);
    check_val("bp_req_count", n_req - base, DEPTH);
    check_val("bp_req_stopped", {31'b0, imem_req_valid}, 32'd0);
    check_val("bp_instr_valid", {31'b0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    steps(8);

    // Memory stall: address held while not accepted.
    imem_req_ready = 1'b0;
    steps(5);
    for (int i = 0; i < 3; i++) begin
      check_val("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check_val("stall_addr", imem_addr, exp_pc);
      step();
    end
    imem_req_ready = 1'b1;
    steps(4);

    // Redirect with two slow requests in flight.
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) step();
    check_val("two_in_flight", mem_q.size(), 32'd2);
    redirect(32'h0000_0100);
    lat = 0;
    check_val("flush_no_req", {31'b0, imem_req_valid}, 32'd0);
    wait_pop("redir", 32'h0000_0100);
    steps(6);

    // Redirect coinciding with a response and a pop.
    instr_ready = 1'b0;
    for (int i = 0; i < 20 && !(instr_valid && mem_q.size() > 0 && due_q[0] <= cyc); i++) step();
    check_val("coinc_setup", {31'b0, instr_valid && mem_q.size() > 0}, 32'd1);
    instr_ready = 1'b1;
    redirect(32'h0000_0300);
    check_val("coinc_fifo_empty", {31'b0, instr_valid}, 32'd0);
    wait_pop("coinc", 32'h0000_0300);
    steps(6);

    // PC wrap across 2^32.
    redirect(32'hFFFF_FFF8);
    wait_pop("wrap", 32'hFFFF_FFF8);
    steps(8);

`ifdef FETCH_MISALIGN_EN
    redirect(32'h0000_0102);
    steps(3);
    base = n_req;
    steps(6);
    check_val("mis_flag", {31'b0, misaligned}, 32'd1);
    check_val("mis_no_req", n_req - base, 32'd0);
    redirect(32'h0000_0200);
    check_val("mis_cleared", {31'b0, misaligned}, 32'd0);
    wait_pop("mis_resume", 32'h0000_0200);
`else
    redirect(32'h0000_0102);
    wait_pop("align_force", 32'h0000_0100);
    check_val("mis_tied0", {31'b0, misaligned}, 32'd0);
`endif
    steps(6);

    // Drain: every expected word must have been delivered.
    imem_req_ready = 1'b0;
    steps(10);
    check_val("drain_exp_q", exp_q.size(), 32'd0);
    check_val("drain_mem_q", mem_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
